// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame sequencer.
//   seq_state_t : sequencer FSM states
//   DEN_MIN     : smallest denominator handed to norm_reader (never 0)
//   frame_pix() : pixels expected in one cropped frame
package frame_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE          = 3'd0,
      ST_LAUNCH        = 3'd1,
      ST_WAIT_CF_READY = 3'd2,
      ST_WAIT_DONE     = 3'd3,
      ST_FINISH        = 3'd4,
      ST_ERR           = 3'd5
   } seq_state_t;

   localparam logic [7:0] DEN_MIN = 8'd1;

   function automatic int frame_pix(input int rows, input int cols);
      return rows * cols;
   endfunction

endpackage

// File: rtl/frame_max_tracker.sv
// Snoops the crop-filter output stream during a frame.
// Keeps the running pixel maximum and a saturating beat counter, and loads
// the norm_reader denominator (zero replaced by DEN_MIN) on cf_ap_done.
// Ports:
//   clk, srst           : clock, synchronous active-high reset
//   i_clear             : start of a new frame, clears max and beat count
//   i_active            : sequencer is outside IDLE
//   i_beat, i_data      : accepted snoop beat and its pixel
//   i_cf_done           : crop-filter done pulse
//   o_denominator       : registered frame maximum
//   o_size_mismatch     : done arrived with a beat count other than a full frame
module frame_max_tracker
   import frame_seq_pkg::*;
#(
   parameter int OUT_ROWS = 10,
   parameter int OUT_COLS = 10
) (
   input  logic       clk,
   input  logic       srst,
   input  logic       i_clear,
   input  logic       i_active,
   input  logic       i_beat,
   input  logic [7:0] i_data,
   input  logic       i_cf_done,
   output logic [7:0] o_denominator,
   output logic       o_size_mismatch
);

   localparam int PIX = frame_pix(OUT_ROWS, OUT_COLS);
   localparam int CW  = ($clog2(PIX + 2) > 8) ? $clog2(PIX + 2) : 8;
   localparam logic [CW-1:0] CNT_SAT  = CW'(PIX + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(PIX);

   logic [7:0]    r_run_max;
   logic [CW-1:0] r_beat_cnt;
   logic [7:0]    r_den;
   logic          w_beat;
   logic [7:0]    w_cur_max;
   logic [CW-1:0] w_cnt_next;

   assign w_beat = i_active & i_beat;

   // The beat in flight this cycle is folded in so a last beat that lands
   // together with cf_ap_done is counted in both the max and the size check.
   assign w_cur_max  = (w_beat && (i_data > r_run_max)) ? i_data : r_run_max;
   assign w_cnt_next = (w_beat && (r_beat_cnt != CNT_SAT)) ? r_beat_cnt + 1'b1 : r_beat_cnt;

   always_ff @(posedge clk) begin
      if (srst) begin
         r_run_max  <= '0;
         r_beat_cnt <= '0;
         r_den      <= DEN_MIN;
      end else begin
         if (i_clear) begin
            r_run_max  <= '0;
            r_beat_cnt <= '0;
         end else begin
            r_run_max  <= w_cur_max;
            r_beat_cnt <= w_cnt_next;
         end
         if (i_active && i_cf_done)
            r_den <= (w_cur_max == 8'd0) ? DEN_MIN : w_cur_max;
      end
   end

   assign o_denominator   = r_den;
   assign o_size_mismatch = i_active & i_cf_done & (w_cnt_next != CNT_FULL);

endmodule

// File: rtl/frame_seq_ctrl.sv
// Sequences one frame pass through crop-filter and norm_reader.
// norm_reader is started in LAUNCH together with crop-filter so its ready
// gate is armed before cf_ap_done can arrive. Completion waits for both done
// pulses in any order; every wait state is guarded by a cycle timeout.
// Ports:
//   clk, srst                 : clock, synchronous active-high reset
//   frame_start, clear_err    : host requests
//   cf_ap_start/ready/done    : crop-filter control (start held until ready)
//   nr_ap_start/done          : norm_reader control (start is one pulse)
//   seq_ap_idle               : norm_reader sequencer-idle gate
//   snoop_tvalid/tready/tdata : observed crop-filter output stream
//   norm_denominator          : frame maximum for norm_reader
//   busy, frame_done, frame_count : status
//   timeout_err, size_err, overrun_err : sticky error flags
//   dbg_state                 : current FSM state
//
// Handshakes: a stream beat counts only when snoop_tvalid and snoop_tready are
// both high on a rising edge; cf_ap_start stays high until cf_ap_ready (or
// cf_ap_done) has been seen, after which it drops.
module frame_seq_ctrl
   import frame_seq_pkg::*;
#(
   parameter int OUT_ROWS       = 10,
   parameter int OUT_COLS       = 10,
   parameter int TIMEOUT_CYCLES = 2**20
) (
   input  logic        clk,
   input  logic        srst,
   input  logic        frame_start,
   input  logic        clear_err,
   output logic        cf_ap_start,
   input  logic        cf_ap_ready,
   input  logic        cf_ap_done,
   output logic        nr_ap_start,
   input  logic        nr_ap_done,
   output logic        seq_ap_idle,
   input  logic        snoop_tvalid,
   input  logic        snoop_tready,
   input  logic [7:0]  snoop_tdata,
   output logic [7:0]  norm_denominator,
   output logic        busy,
   output logic        frame_done,
   output logic [15:0] frame_count,
   output logic        timeout_err,
   output logic        size_err,
   output logic        overrun_err,
   output logic [2:0]  dbg_state
);

   localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

   seq_state_t    r_state;
   seq_state_t    w_next;
   logic [TW-1:0] r_tmo_cnt;
   logic          r_cf_done_f;
   logic          r_nr_done_f;
   logic          r_frame_done;
   logic [15:0]   r_frame_count;
   logic          r_timeout_err;
   logic          r_size_err;
   logic          r_overrun_err;
   logic          w_in_wait;
   logic          w_tmo_hit;
   logic          w_cf_seen;
   logic          w_nr_seen;
   logic          w_new_frame;
   logic          w_size_mismatch;

   assign w_in_wait   = (r_state == ST_WAIT_CF_READY) || (r_state == ST_WAIT_DONE);
   assign w_tmo_hit   = w_in_wait && (r_tmo_cnt == TMO_LAST);
   assign w_cf_seen   = r_cf_done_f | cf_ap_done;
   assign w_nr_seen   = r_nr_done_f | nr_ap_done;
   assign w_new_frame = (r_state == ST_IDLE) && frame_start;

   always_comb begin
      w_next      = r_state;
      cf_ap_start = 1'b0;
      nr_ap_start = 1'b0;
      seq_ap_idle = 1'b0;
      busy        = 1'b1;
      case (r_state)
         ST_IDLE: begin
            seq_ap_idle = 1'b1;
            busy        = 1'b0;
            if (frame_start) w_next = ST_LAUNCH;
         end
         ST_LAUNCH: begin
            cf_ap_start = 1'b1;
            nr_ap_start = 1'b1;
            seq_ap_idle = 1'b1;
            w_next      = cf_ap_ready ? ST_WAIT_DONE : ST_WAIT_CF_READY;
         end
         ST_WAIT_CF_READY: begin
            cf_ap_start = 1'b1;
            if (cf_ap_ready || cf_ap_done) w_next = ST_WAIT_DONE;
            else if (w_tmo_hit)            w_next = ST_ERR;
         end
         ST_WAIT_DONE: begin
            if (w_cf_seen && w_nr_seen) w_next = ST_FINISH;
            else if (w_tmo_hit)         w_next = ST_ERR;
         end
         ST_FINISH: begin
            w_next = ST_IDLE;
         end
         ST_ERR: begin
            busy = 1'b0;
            if (clear_err) w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (srst) begin
         r_state       <= ST_IDLE;
         r_tmo_cnt     <= '0;
         r_cf_done_f   <= 1'b0;
         r_nr_done_f   <= 1'b0;
         r_frame_done  <= 1'b0;
         r_frame_count <= '0;
         r_timeout_err <= 1'b0;
         r_size_err    <= 1'b0;
         r_overrun_err <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_frame_done <= (w_next == ST_FINISH);
         if (w_next == ST_FINISH)
            r_frame_count <= r_frame_count + 16'd1;

         // Restarts on every state change, so each wait state gets a full budget.
         if ((w_next != r_state) || !w_in_wait) r_tmo_cnt <= '0;
         else                                  r_tmo_cnt <= r_tmo_cnt + 1'b1;

         if (w_new_frame) begin
            r_cf_done_f <= 1'b0;
            r_nr_done_f <= 1'b0;
         end else if (busy) begin
            r_cf_done_f <= w_cf_seen;
            r_nr_done_f <= w_nr_seen;
         end

         if ((r_state == ST_ERR) && clear_err) begin
            r_timeout_err <= 1'b0;
            r_size_err    <= 1'b0;
            r_overrun_err <= 1'b0;
         end else begin
            if (w_tmo_hit && (w_next == ST_ERR)) r_timeout_err <= 1'b1;
            if (w_size_mismatch)                 r_size_err    <= 1'b1;
            if (busy && frame_start)             r_overrun_err <= 1'b1;
         end
      end
   end

   frame_max_tracker #(
      .OUT_ROWS (OUT_ROWS),
      .OUT_COLS (OUT_COLS)
   ) u_tracker (
      .clk             (clk),
      .srst            (srst),
      .i_clear         (w_new_frame),
      .i_active        (r_state != ST_IDLE),
      .i_beat          (snoop_tvalid & snoop_tready),
      .i_data          (snoop_tdata),
      .i_cf_done       (cf_ap_done),
      .o_denominator   (norm_denominator),
      .o_size_mismatch (w_size_mismatch)
   );

   assign frame_done  = r_frame_done;
   assign frame_count = r_frame_count;
   assign timeout_err = r_timeout_err;
   assign size_err    = r_size_err;
   assign overrun_err = r_overrun_err;
   assign dbg_state   = r_state;

endmodule

// File: tb/tb_frame_seq_ctrl.sv
// Directed bench for frame_seq_ctrl. A second instance with a 16-cycle
// timeout shares the inputs and is only examined in the timeout scenario.
module tb_frame_seq_ctrl;

   logic        clk;
   logic        srst;
   logic        frame_start;
   logic        clear_err;
   logic        cf_ap_ready;
   logic        cf_ap_done;
   logic        nr_ap_done;
   logic        snoop_tvalid;
   logic        snoop_tready;
   logic [7:0]  snoop_tdata;

   logic        cf_ap_start, nr_ap_start, seq_ap_idle, busy, frame_done;
   logic        timeout_err, size_err, overrun_err;
   logic [7:0]  norm_denominator;
   logic [15:0] frame_count;
   logic [2:0]  dbg_state;

   logic        t_cf_ap_start, t_nr_ap_start, t_seq_ap_idle, t_busy, t_frame_done;
   logic        t_timeout_err, t_size_err, t_overrun_err;
   logic [7:0]  t_norm_denominator;
   logic [15:0] t_frame_count;
   logic [2:0]  t_dbg_state;

   int          n_checks;
   int          n_fail;
   int          exp_count;
   logic [7:0]  exp_q[$];
   logic [7:0]  pix_q[$];

   frame_seq_ctrl #(.OUT_ROWS(10), .OUT_COLS(10)) dut (
      .clk(clk), .srst(srst), .frame_start(frame_start), .clear_err(clear_err),
      .cf_ap_start(cf_ap_start), .cf_ap_ready(cf_ap_ready), .cf_ap_done(cf_ap_done),
      .nr_ap_start(nr_ap_start), .nr_ap_done(nr_ap_done), .seq_ap_idle(seq_ap_idle),
      .snoop_tvalid(snoop_tvalid), .snoop_tready(snoop_tready), .snoop_tdata(snoop_tdata),
      .norm_denominator(norm_denominator), .busy(busy), .frame_done(frame_done),
      .frame_count(frame_count), .timeout_err(timeout_err), .size_err(size_err),
      .overrun_err(overrun_err), .dbg_state(dbg_state)
   );

   frame_seq_ctrl #(.OUT_ROWS(10), .OUT_COLS(10), .TIMEOUT_CYCLES(16)) dut_t (
      .clk(clk), .srst(srst), .frame_start(frame_start), .clear_err(clear_err),
      .cf_ap_start(t_cf_ap_start), .cf_ap_ready(cf_ap_ready), .cf_ap_done(cf_ap_done),
      .nr_ap_start(t_nr_ap_start), .nr_ap_done(nr_ap_done), .seq_ap_idle(t_seq_ap_idle),
      .snoop_tvalid(snoop_tvalid), .snoop_tready(snoop_tready), .snoop_tdata(snoop_tdata),
      .norm_denominator(t_norm_denominator), .busy(t_busy), .frame_done(t_frame_done),
      .frame_count(t_frame_count), .timeout_err(t_timeout_err), .size_err(t_size_err),
      .overrun_err(t_overrun_err), .dbg_state(t_dbg_state)
   );

   // clock / reset
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // Drives one frame from pix_q; checks launch, denominator and completion.
   task automatic do_frame(input int ready_dly, input bit nr_first,
                           input bit last_with_done, input bit ovr);
      logic [7:0] exp_den;
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_val("launch_nr_start", nr_ap_start, 1);
      check_val("launch_cf_start", cf_ap_start, 1);
      check_val("launch_idle_gate", seq_ap_idle, 1);
      for (int k = 0; k < ready_dly; k++) tick();
      if (ready_dly > 0) begin
         check_val("wait_ready_cf_start_held", cf_ap_start, 1);
         check_val("wait_ready_nr_start_low", nr_ap_start, 0);
      end
      cf_ap_ready = 1'b1;
      tick();
      cf_ap_ready = 1'b0;
      check_val("wait_done_cf_start_low", cf_ap_start, 0);
      if (ovr) begin
         frame_start = 1'b1;
         tick();
         frame_start = 1'b0;
      end
      if (nr_first) begin
         nr_ap_done = 1'b1;
         tick();
         nr_ap_done = 1'b0;
      end
      // offered but not accepted: must not affect the max
      snoop_tvalid = 1'b1;
      snoop_tready = 1'b0;
      snoop_tdata  = 8'hFF;
      tick();
      for (int i = 0; i < pix_q.size(); i++) begin
         snoop_tvalid = 1'b1;
         snoop_tready = 1'b1;
         snoop_tdata  = pix_q[i];
         if (last_with_done && (i == pix_q.size() - 1)) cf_ap_done = 1'b1;
         tick();
      end
      snoop_tvalid = 1'b0;
      snoop_tready = 1'b0;
      if (last_with_done) begin
         cf_ap_done = 1'b0;
      end else begin
         cf_ap_done = 1'b1;
         tick();
         cf_ap_done = 1'b0;
      end
      exp_den = exp_q.pop_front();
      check_val("norm_denominator", norm_denominator, exp_den);
      if (!nr_first) begin
         check_val("hold_until_nr_done", frame_done, 0);
         nr_ap_done = 1'b1;
         tick();
         nr_ap_done = 1'b0;
      end
      exp_count++;
      check_val("frame_done_pulse", frame_done, 1);
      check_val("frame_count", frame_count, exp_count);
      tick();
      check_val("frame_done_drop", frame_done, 0);
      check_val("idle_busy", busy, 0);
      check_val("idle_gate", seq_ap_idle, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_busy"}, busy, 0);
      check_val({tag, "_cf_start"}, cf_ap_start, 0);
      check_val({tag, "_nr_start"}, nr_ap_start, 0);
      check_val({tag, "_idle_gate"}, seq_ap_idle, 1);
      check_val({tag, "_den"}, norm_denominator, 1);
      check_val({tag, "_count"}, frame_count, 0);
      check_val({tag, "_frame_done"}, frame_done, 0);
      check_val({tag, "_flags"}, {timeout_err, size_err, overrun_err}, 0);
   endtask

   initial begin
      int n;
      n_checks = 0;
      n_fail = 0;
      exp_count = 0;
      srst = 1'b1;
      frame_start = 1'b0;
      clear_err = 1'b0;
      cf_ap_ready = 1'b0;
      cf_ap_done = 1'b0;
      nr_ap_done = 1'b0;
      snoop_tvalid = 1'b0;
      snoop_tready = 1'b0;
      snoop_tdata = 8'd0;
      tick(); tick(); tick();
      srst = 1'b0;
      tick();
      check_reset_outputs("reset");

      // nominal ramp 0..99, immediate ready
      pix_q.delete();
      for (int i = 0; i < 100; i++) pix_q.push_back(8'(i));
      exp_q.push_back(8'd99);
      do_frame(0, 1'b0, 1'b0, 1'b0);
      check_val("nominal_flags", {timeout_err, size_err, overrun_err}, 0);

      // all-zero frame: denominator guarded to 1
      pix_q.delete();
      for (int i = 0; i < 100; i++) pix_q.push_back(8'd0);
      exp_q.push_back(8'd1);
      do_frame(0, 1'b0, 1'b0, 1'b0);

      // last beat 200 coincides with cf_ap_done
      pix_q.delete();
      for (int i = 0; i < 99; i++) pix_q.push_back(8'd0);
      pix_q.push_back(8'd200);
      exp_q.push_back(8'd200);
      do_frame(0, 1'b0, 1'b1, 1'b0);
      check_val("same_cycle_last_no_size_err", size_err, 0);

      // nr_ap_done first, ready delayed 5 cycles; (i*7)%128 peaks at 127 (i=73)
      pix_q.delete();
      for (int i = 0; i < 100; i++) pix_q.push_back(8'((i * 7) % 128));
      exp_q.push_back(8'd127);
      do_frame(5, 1'b1, 1'b0, 1'b0);
      check_val("reordered_flags", {timeout_err, size_err, overrun_err}, 0);

      // short frame (99 beats) plus a frame_start while busy
      pix_q.delete();
      for (int i = 0; i < 99; i++) pix_q.push_back(8'(i));
      exp_q.push_back(8'd98);
      do_frame(0, 1'b0, 1'b0, 1'b1);
      check_val("short_size_err", size_err, 1);
      check_val("busy_start_overrun_err", overrun_err, 1);
      check_val("short_timeout_err", timeout_err, 0);

      // srst in WAIT_DONE
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      cf_ap_ready = 1'b1;
      tick();
      cf_ap_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         snoop_tvalid = 1'b1;
         snoop_tready = 1'b1;
         snoop_tdata  = 8'(50 + i);
         tick();
      end
      snoop_tvalid = 1'b0;
      snoop_tready = 1'b0;
      check_val("pre_srst_busy", busy, 1);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      check_reset_outputs("srst_mid");
      exp_count = 0;
      pix_q.delete();
      for (int i = 0; i < 100; i++) pix_q.push_back(8'(i));
      exp_q.push_back(8'd99);
      do_frame(0, 1'b0, 1'b0, 1'b0);
      check_val("post_srst_flags", {timeout_err, size_err, overrun_err}, 0);

      // timeout on the 16-cycle instance
      srst = 1'b1;
      tick(); tick();
      srst = 1'b0;
      tick();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      cf_ap_ready = 1'b1;
      tick();
      cf_ap_ready = 1'b0;
      n = 0;
      while (t_busy && (n < 40)) begin
         tick();
         n++;
      end
      check_val("timeout_wait_cycles", n, 16);
      check_val("timeout_err_set", t_timeout_err, 1);
      check_val("timeout_busy", t_busy, 0);
      check_val("err_idle_gate", t_seq_ap_idle, 0);
      check_val("err_cf_start", t_cf_ap_start, 0);
      check_val("long_timeout_not_hit", timeout_err, 0);
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      check_val("err_start_no_overrun", t_overrun_err, 0);
      check_val("err_start_ignored", t_seq_ap_idle, 0);
      clear_err = 1'b1;
      frame_start = 1'b1;
      tick();
      clear_err = 1'b0;
      frame_start = 1'b0;
      check_val("clear_err_idle", t_seq_ap_idle, 1);
      check_val("clear_err_flags", {t_timeout_err, t_size_err, t_overrun_err}, 0);
      check_val("clear_err_start_dropped", t_nr_ap_start, 0);
      tick();
      check_val("clear_err_stays_idle", t_busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
